// File: rtl/link_pkg.sv
// Shared definitions for the "100"-framed serial link: FSM encoding and
// the default sync preamble recognised by the link's sequence detector.
package link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    localparam int                     DEF_PRE_LEN  = 3;
    localparam logic [DEF_PRE_LEN-1:0] DEF_PREAMBLE = 3'b100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Parallel valid/ready word channel from the producer into the serializer.
interface frame_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register; msb is the next payload bit to go out.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             msb
);
    logic [WIDTH-1:0] shreg_reg;

    // load wins over shift so a back-to-back accept never loses the new word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_reg <= '0;
        end else if (load) begin
            shreg_reg <= data_in;
        end else if (shift) begin
            shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg_reg[WIDTH-1];
endmodule

// File: rtl/frame_serializer.sv
// Serializes accepted words MSB-first onto x, each preceded by the sync preamble.
// Back-to-back words are accepted on the done cycle so frames run with no gap.
module frame_serializer
    import link_pkg::*;
#(
    parameter int                 WIDTH    = 8,
    parameter int                 PRE_LEN  = DEF_PRE_LEN,
    parameter logic [PRE_LEN-1:0] PREAMBLE = DEF_PREAMBLE
) (
    input  logic               clk,
    input  logic               reset,
    frame_serializer_if.slave  bus,
    output logic               x,
    output logic               busy,
    output logic               done
);
    localparam int CNT_W     = $clog2(max_int(WIDTH, PRE_LEN));
    localparam int PRE_EXT_W = 1 << CNT_W;
    // Preamble widened so the counter can index it directly
    localparam logic [PRE_EXT_W-1:0] PRE_EXT = PRE_EXT_W'(PREAMBLE);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_dec;
    logic               x_reg, x_next;
    logic               done_reg, done_next;
    logic               load, shift, msb, accept, cnt_zero;

    assign cnt_zero  = (cnt_reg == '0);
    assign cnt_dec   = cnt_reg - CNT_W'(1);
    assign bus.ready = (state_reg == ST_IDLE) || ((state_reg == ST_DATA) && cnt_zero);
    assign accept    = bus.valid && bus.ready;

    piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .data_in (bus.data_in),
        .msb     (msb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_PRE;
            ST_PRE:  if (cnt_zero) state_next = ST_DATA;
            ST_DATA: if (cnt_zero) state_next = accept ? ST_PRE : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        x_next    = x_reg;
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                x_next = 1'b0;
                if (accept) begin
                    load     = 1'b1;
                    x_next   = PREAMBLE[PRE_LEN-1];
                    cnt_next = CNT_W'(PRE_LEN - 1);
                end
            end
            ST_PRE: begin
                if (cnt_zero) begin
                    // first payload bit goes out while the register advances to the next
                    x_next   = msb;
                    shift    = 1'b1;
                    cnt_next = CNT_W'(WIDTH - 1);
                end else begin
                    x_next   = PRE_EXT[cnt_dec];
                    cnt_next = cnt_dec;
                end
            end
            ST_DATA: begin
                if (cnt_zero) begin
                    if (accept) begin
                        load     = 1'b1;
                        x_next   = PREAMBLE[PRE_LEN-1];
                        cnt_next = CNT_W'(PRE_LEN - 1);
                    end else begin
                        x_next   = 1'b0;
                    end
                end else begin
                    x_next    = msb;
                    shift     = 1'b1;
                    cnt_next  = cnt_dec;
                    done_next = (cnt_dec == '0);
                end
            end
            default: x_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= '0;
            x_reg    <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            x_reg    <= x_next;
            done_reg <= done_next;
        end
    end

    assign x    = x_reg;
    assign done = done_reg;
    assign busy = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: reset, single, back-to-back, held valid,
// mid-frame async reset, and a loopback "100" detector on x.
module tb_frame_serializer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic x, busy, done;
    int   checks = 0;
    int   errors = 0;

    frame_serializer_if #(.WIDTH(8)) bus ();

    frame_serializer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .x     (x),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Loopback sequence detector: y registers one cycle after 1,0,0 is seen on x
    logic [2:0] hist  = 3'b000;
    logic       det_y = 1'b0;
    always @(posedge clk) begin
        hist  <= {hist[1:0], x};
        det_y <= ({hist[1:0], x} == 3'b100);
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ex, input logic eb,
                           input logic ed, input logic er);
        chk({tag, "/x"},     x,         ex);
        chk({tag, "/busy"},  busy,      eb);
        chk({tag, "/done"},  done,      ed);
        chk({tag, "/ready"}, bus.ready, er);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Accept d0 now; if two frames, offer d1 from cycle hold_from up to the done cycle
    task automatic run_stream(input string tag, input logic [7:0] d0, input int nframes,
                              input logic [7:0] d1, input int hold_from);
        logic [21:0] bits;
        int          nbits;
        bits  = {3'b100, d0, 3'b100, d1};
        nbits = 11 * nframes;
        chk({tag, "/accept_ready"}, bus.ready, 1'b1);
        bus.data_in = d0;
        bus.valid   = 1'b1;
        cyc();
        bus.valid   = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            int   pos;
            logic last;
            pos  = i % 11;
            last = (pos == 10);
            chk_out($sformatf("%s[%0d]", tag, i), bits[21-i], 1'b1, last, last);
            if (pos == 3) chk($sformatf("%s[%0d]/det_y", tag, i), det_y, 1'b1);
            if (nframes == 2 && i >= hold_from && i <= 10) begin
                bus.data_in = d1;
                bus.valid   = 1'b1;
            end
            cyc();
            bus.valid = 1'b0;
        end
        chk_out({tag, "/idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("stream %s: data0=%h frames=%0d data1=%h", tag, d0, nframes, d1);
    endtask

    initial begin
        bus.data_in = 8'h00;
        bus.valid   = 1'b0;

        // Reset held for two cycles, then idle with valid low
        cyc();
        cyc();
        chk_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        $display("reset: released, idle outputs checked");

        run_stream("a5", 8'hA5, 1, 8'h00, 0);
        run_stream("ff_00", 8'hFF, 2, 8'h00, 10);
        run_stream("5a_hold3c", 8'h5A, 2, 8'h3C, 1);

        // Asynchronous reset in the middle of a frame
        bus.data_in = 8'hA5;
        bus.valid   = 1'b1;
        cyc();
        bus.valid   = 1'b0;
        chk_out("abort[0]", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_out("abort[1]", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_out("abort[2]", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_out("abort[3]", 1'b1, 1'b1, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 chk_out("abort_async", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk_out("abort_released", 1'b0, 1'b0, 1'b0, 1'b1);
        $display("abort: reset mid-frame, outputs dropped");

        run_stream("81", 8'h81, 1, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
